// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and default width for the multiply sequencer
package mul_seq_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/mul_seq_dp.sv
// mul_seq_dp: operand/product registers, shift-add step, sign fix and accumulate
// Ports: load captures operands, step does one radix-2 iteration, fix writes result_hi/result_lo.
module mul_seq_dp
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             is_signed,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, acc_q, acc_d, res_q, res_d;
  logic               neg_q, neg_d, acc_en_q, acc_en_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] signed_p;
  // Magnitude of the most negative value is 2^(W-1), which still fits unsigned.
  always_comb begin
    sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mplier_q[0] ? mcand_q : '0};
    signed_p = neg_q ? -prod_q : prod_q;
    mcand_d  = load ? ((is_signed & a[WIDTH-1]) ? -a : a) : mcand_q;
    mplier_d = load ? ((is_signed & b[WIDTH-1]) ? -b : b) : step ? mplier_q >> 1 : mplier_q;
    prod_d   = load ? '0 : step ? {sum, prod_q[WIDTH-1:1]} : prod_q;
    neg_d    = load ? is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) : neg_q;
    acc_en_d = load ? acc_en : acc_en_q;
    acc_d    = load ? {acc_hi, acc_lo} : acc_q;
    res_d    = fix ? signed_p + (acc_en_q ? acc_q : '0) : res_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      acc_en_q <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
    end
  end
  assign {result_hi, result_lo} = res_q;
endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiply sequencer (signed/unsigned, optional accumulate)
// Ports: start/flush control, is_signed/acc_en mode, a/b operands, acc_hi/acc_lo addend;
// busy (RUN/FIX), done one-cycle pulse, result_hi/result_lo registered product.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);
  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          load, step, fix;
  always_comb begin
    load    = (state_q == IDLE) & start & ~flush;
    step    = (state_q == RUN) & ~flush;
    fix     = (state_q == FIX) & ~flush;
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          count_d = CW'(WIDTH);
        end
        RUN: begin
          count_d = count_q - CW'(1);
          state_d = (count_q == CW'(1)) ? FIX : RUN;
        end
        FIX:     state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    // busy/done are registered from the next state so they line up with it.
    busy_d = (state_d == RUN) | (state_d == FIX);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .is_signed (is_signed),
    .acc_en    (acc_en),
    .a         (a),
    .b         (b),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized and directed checks of mul_seq against a 64-bit arithmetic model
module tb_mul_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic        is_signed = 1'b0, acc_en = 1'b0;
  logic [31:0] a = '0, b = '0, acc_hi = '0, acc_lo = '0;
  logic        busy, done;
  logic [31:0] result_hi, result_lo;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .is_signed(is_signed),
    .acc_en(acc_en), .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic ae, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] acc);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye + (ae ? acc : 64'd0);
  endfunction
  task automatic launch(input logic s, input logic ae, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] acc);
    @(negedge clk);
    start = 1'b1; is_signed = s; acc_en = ae; a = x; b = y; {acc_hi, acc_lo} = acc;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; {acc_hi, acc_lo} = {$urandom, $urandom};
    is_signed = $urandom_range(0, 1); acc_en = $urandom_range(0, 1);
  endtask
  task automatic do_op(input string tag, input logic s, input logic ae, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] acc, input logic restart);
    int lat, busy_n;
    logic held;
    logic [63:0] prev, exp;
    exp = model(s, ae, x, y, acc);
    prev = {result_hi, result_lo};
    held = 1'b1;
    launch(s, ae, x, y, acc);
    lat = 1;
    busy_n = 0;
    while (!done && lat < 60) begin
      busy_n += int'(busy);
      if ({result_hi, result_lo} !== prev) held = 1'b0;
      if (restart && lat == 5) begin
        start = 1'b1; a = ~x; b = y + 32'd3;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'd34);
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, " hold"}, 64'(held), 64'd1);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " result"}, {result_hi, result_lo}, exp);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask
  task automatic abort_op(input string tag, input logic use_reset);
    int dn;
    logic [63:0] prev;
    prev = {result_hi, result_lo};
    launch(1'b0, 1'b0, 32'h1234_5678, 32'h9abc_def0, 64'd0);
    repeat (9) @(negedge clk);
    if (use_reset) begin
      #2 reset = 1'b1;
      #1;
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " result"}, {result_hi, result_lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk({tag, " busy"}, 64'(busy), 64'd0);
    end
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk({tag, " no_done"}, 64'(dn), 64'd0);
    chk({tag, " result_kept"}, {result_hi, result_lo}, use_reset ? 64'd0 : prev);
  endtask
  initial begin
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", {result_hi, result_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("u3x5", 1'b0, 1'b0, 32'd3, 32'd5, 64'd0, 1'b0);
    chk("u3x5 const", {result_hi, result_lo}, 64'h0000_0000_0000_000F);
    do_op("s-3x7", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'd0, 1'b0);
    chk("s-3x7 const", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("u-3x7", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'd0, 1'b0);
    chk("u-3x7 const", {result_hi, result_lo}, 64'h0000_0006_FFFF_FFEB);
    do_op("smin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0, 1'b0);
    chk("smin const", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
    do_op("umax", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);
    chk("umax const", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("uacc", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 64'd1, 1'b0);
    chk("uacc const", {result_hi, result_lo}, 64'h0000_0001_0000_0000);
    do_op("sacc", 1'b1, 1'b1, 32'd2, 32'hFFFF_FFFF, 64'd1, 1'b0);
    chk("sacc const", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    do_op("restart", 1'b0, 1'b0, 32'd11, 32'd13, 64'd0, 1'b1);
    do_op("after", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd9, 64'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_wins busy", 64'(busy), 64'd0);
    abort_op("flush", 1'b0);
    abort_op("areset", 1'b1);
    do_op("post_reset", 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0001, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int i = 0; i < 20; i++)
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, {$urandom, $urandom}, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
